// File: rtl/game_flow_ctrl_pkg.sv
// Shared widths and state encoding for the game round sequencer and its timer.
package game_flow_ctrl_pkg;

  localparam int unsigned GAME_TIME_W = 13;
  localparam int unsigned SEC_W       = 6;
  localparam int unsigned HUND_W      = 7;
  localparam int unsigned PAIRS_W     = 6;
  localparam int unsigned HUND_MAX    = 99;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_WON     = 2'd2,
    ST_LOST    = 2'd3
  } state_e;

endpackage

// File: rtl/game_timer_bcd_free.sv
// Round timer: hundredths prescaler plus {seconds, hundredths} counter with
// a look-ahead flag that fires when the next value reaches the time limit.
module game_timer_bcd_free
  import game_flow_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 40_000_000,
  parameter int unsigned TIME_LIMIT_S = 60
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   run,
  output logic                   tick,
  output logic [GAME_TIME_W-1:0] game_time,
  output logic                   limit_hit
);

  localparam int unsigned PRESC_N = CLK_HZ / 100;
  localparam int unsigned PRESC_W = $clog2(PRESC_N);
  localparam logic [PRESC_W-1:0]     PRESC_TC = PRESC_W'(PRESC_N - 1);
  localparam logic [GAME_TIME_W-1:0] LIMIT    = {SEC_W'(TIME_LIMIT_S), HUND_W'(0)};

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SEC_W-1:0]   sec_q, sec_d, sec_inc;
  logic [HUND_W-1:0]  hund_q, hund_d, hund_inc;

  always_comb begin
    tick = run && (presc_q == PRESC_TC);

    if (hund_q == HUND_W'(HUND_MAX)) begin
      hund_inc = '0;
      sec_inc  = sec_q + SEC_W'(1);
    end else begin
      hund_inc = hund_q + HUND_W'(1);
      sec_inc  = sec_q;
    end

    // Look-ahead so the FSM can stop the round on the same edge the limit is reached.
    limit_hit = tick && ({sec_inc, hund_inc} == LIMIT);

    presc_d = presc_q;
    sec_d   = sec_q;
    hund_d  = hund_q;
    if (clr) begin
      presc_d = '0;
      sec_d   = '0;
      hund_d  = '0;
    end else if (run) begin
      presc_d = (presc_q == PRESC_TC) ? '0 : presc_q + PRESC_W'(1);
      if (tick) begin
        sec_d  = sec_inc;
        hund_d = hund_inc;
      end
    end else begin
      presc_d = '0;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      sec_q   <= '0;
      hund_q  <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      hund_q  <= hund_d;
    end
  end

  assign game_time = {sec_q, hund_q};

endmodule

// File: rtl/game_flow_ctrl.sv
// Game round sequencer: IDLE -> RUNNING -> WON/LOST, driving the endgame
// screen with the round time, pair count and win/loss flags.
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 40_000_000,
  parameter int unsigned MAX_PAIRS    = 18,
  parameter int unsigned TIME_LIMIT_S = 60
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   restart,
  input  logic                   pair_found,
  output logic [GAME_TIME_W-1:0] game_time,
  output logic [PAIRS_W-1:0]     discovered_pairs_ctr,
  output logic                   game_active,
  output logic                   endscreen_en,
  output logic                   game_over_en
);

  state_e             state_q, state_d;
  logic [PAIRS_W-1:0] pairs_q, pairs_d, pairs_inc;
  logic               clr, run, tick, limit_hit, win;

  game_timer_bcd_free #(
    .CLK_HZ       (CLK_HZ),
    .TIME_LIMIT_S (TIME_LIMIT_S)
  ) u_timer (
    .pclk      (pclk),
    .rst       (rst),
    .clr       (clr),
    .run       (run),
    .tick      (tick),
    .game_time (game_time),
    .limit_hit (limit_hit)
  );

  assign run = (state_q == ST_RUNNING);

  always_comb begin
    state_d   = state_q;
    pairs_d   = pairs_q;
    clr       = 1'b0;
    pairs_inc = pairs_q + PAIRS_W'(1);
    win       = pair_found && (pairs_inc == PAIRS_W'(MAX_PAIRS));

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUNNING;
          clr     = 1'b1;
          pairs_d = '0;
        end
      end
      ST_RUNNING: begin
        if (pair_found && (pairs_q < PAIRS_W'(MAX_PAIRS))) begin
          pairs_d = pairs_inc;
        end
        // A completing pair beats a simultaneous timeout; the tick still lands.
        if (win) begin
          state_d = ST_WON;
        end else if (limit_hit) begin
          state_d = ST_LOST;
        end
      end
      ST_WON, ST_LOST: begin
        if (restart) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
          pairs_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        clr     = 1'b1;
        pairs_d = '0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pairs_q <= '0;
    end else begin
      state_q <= state_d;
      pairs_q <= pairs_d;
    end
  end

  assign discovered_pairs_ctr = pairs_q;
  assign game_active          = (state_q == ST_RUNNING);
  assign endscreen_en         = (state_q == ST_WON) || (state_q == ST_LOST);
  assign game_over_en         = (state_q == ST_LOST);

  // tick is only consumed through limit_hit at this level.
  logic unused_tick;
  assign unused_tick = tick;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl with a 10-cycle tick, 3 pairs, 2 s limit.
module tb_game_flow_ctrl;
  import game_flow_ctrl_pkg::*;

  localparam int unsigned CLK_HZ       = 1000;
  localparam int unsigned MAX_PAIRS    = 3;
  localparam int unsigned TIME_LIMIT_S = 2;

  logic                   pclk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic                   restart = 1'b0;
  logic                   pair_found = 1'b0;
  logic [GAME_TIME_W-1:0] game_time;
  logic [PAIRS_W-1:0]     discovered_pairs_ctr;
  logic                   game_active;
  logic                   endscreen_en;
  logic                   game_over_en;

  always #5 pclk = ~pclk;

  game_flow_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .MAX_PAIRS    (MAX_PAIRS),
    .TIME_LIMIT_S (TIME_LIMIT_S)
  ) dut (
    .pclk                 (pclk),
    .rst                  (rst),
    .start                (start),
    .restart              (restart),
    .pair_found           (pair_found),
    .game_time            (game_time),
    .discovered_pairs_ctr (discovered_pairs_ctr),
    .game_active          (game_active),
    .endscreen_en         (endscreen_en),
    .game_over_en         (game_over_en)
  );

  typedef enum {K_TIME, K_PAIRS, K_ACTIVE, K_END, K_OVER} kind_e;
  typedef struct {
    kind_e       kind;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tval(input int unsigned s, input int unsigned h);
    return 32'(s * 128 + h);
  endfunction

  task automatic push(input string tag, input kind_e k, input logic [31:0] e);
    exp_t x;
    x.kind = k;
    x.tag  = tag;
    x.exp  = e;
    sb_q.push_back(x);
  endtask

  task automatic expect_all(input string tag, input logic [31:0] t, input logic [31:0] p,
                            input logic a, input logic en, input logic ov);
    push(tag, K_TIME, t);
    push(tag, K_PAIRS, p);
    push(tag, K_ACTIVE, 32'(a));
    push(tag, K_END, 32'(en));
    push(tag, K_OVER, 32'(ov));
  endtask

  task automatic drain();
    exp_t        x;
    logic [31:0] obs;
    string       name;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      case (x.kind)
        K_TIME:   begin obs = 32'(game_time);            name = "time";   end
        K_PAIRS:  begin obs = 32'(discovered_pairs_ctr); name = "pairs";  end
        K_ACTIVE: begin obs = 32'(game_active);          name = "active"; end
        K_END:    begin obs = 32'(endscreen_en);         name = "endscr"; end
        default:  begin obs = 32'(game_over_en);         name = "over";   end
      endcase
      check_val({x.tag, "/", name}, obs, x.exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic pulse(input logic s, input logic r, input logic p);
    start      = s;
    restart    = r;
    pair_found = p;
    @(negedge pclk);
    start      = 1'b0;
    restart    = 1'b0;
    pair_found = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst = 1'b0;
    #3;
    expect_all("reset", 0, 0, 0, 0, 0);
    drain();
    @(negedge pclk);
    rst = 1'b1;

    cycles(50);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    expect_all("idle", 0, 0, 0, 0, 0);
    drain();

    pulse(1'b1, 1'b0, 1'b0);
    expect_all("run_start", tval(0, 0), 0, 1, 0, 0);
    drain();
    cycles(1000);
    expect_all("run_1s", tval(1, 0), 0, 1, 0, 0);
    drain();
    @(negedge pclk) rst = 1'b0;
    @(negedge pclk) rst = 1'b1;

    pulse(1'b1, 1'b0, 1'b0);
    cycles(99);
    push("pair1", K_PAIRS, 1);
    push("pair1", K_TIME, tval(0, 10));
    pulse(1'b0, 1'b0, 1'b1);
    drain();
    cycles(99);
    push("pair2", K_PAIRS, 2);
    push("pair2", K_END, 0);
    pulse(1'b0, 1'b0, 1'b1);
    drain();
    cycles(99);
    expect_all("won", tval(0, 30), 3, 0, 1, 0);
    pulse(1'b0, 1'b0, 1'b1);
    drain();
    pulse(1'b1, 1'b0, 1'b1);
    cycles(50);
    expect_all("won_hold", tval(0, 30), 3, 0, 1, 0);
    drain();
    pulse(1'b0, 1'b1, 1'b0);
    expect_all("restart", 0, 0, 0, 0, 0);
    drain();

    pulse(1'b1, 1'b0, 1'b0);
    cycles(1999);
    expect_all("pre_limit", tval(1, 99), 0, 1, 0, 0);
    drain();
    cycles(1);
    expect_all("lost", tval(2, 0), 0, 0, 1, 1);
    drain();
    cycles(500);
    expect_all("lost_hold", tval(2, 0), 0, 0, 1, 1);
    drain();

    pulse(1'b1, 1'b1, 1'b0);
    expect_all("rs_both", 0, 0, 0, 0, 0);
    drain();
    cycles(20);
    expect_all("rs_idle", 0, 0, 0, 0, 0);
    drain();

    pulse(1'b1, 1'b0, 1'b0);
    cycles(99);
    pulse(1'b0, 1'b0, 1'b1);
    cycles(99);
    pulse(1'b0, 1'b0, 1'b1);
    cycles(1799);
    push("tie_pre", K_TIME, tval(1, 99));
    push("tie_pre", K_PAIRS, 2);
    drain();
    expect_all("tie", tval(2, 0), 3, 0, 1, 0);
    pulse(1'b0, 1'b0, 1'b1);
    drain();
    pulse(1'b0, 1'b1, 1'b0);

    pulse(1'b1, 1'b0, 1'b0);
    cycles(500);
    #2 rst = 1'b0;
    #1;
    expect_all("async_rst", 0, 0, 0, 0, 0);
    drain();
    @(negedge pclk) rst = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    expect_all("after_rst", tval(0, 0), 0, 1, 0, 0);
    drain();
    cycles(10);
    push("after_rst_tick", K_TIME, tval(0, 1));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Sequences one game round for the endgame screen datapath.
- Runs the round timer as {seconds, hundredths}, counts discovered pairs, and decides win or loss.
- Drives the screen's `enable`, `game_over_en`, `game_time` and `discovered_pairs_ctr` inputs.
- Sits between the card/match logic, which pulses `pair_found`, and the endgame screen overlay.

Parameters:
- CLK_HZ, 40_000_000, pclk frequency in Hz. CLK_HZ/100 must be an integer ≥ 2.
- MAX_PAIRS, 18, pairs needed to win. Range 1..63.
- TIME_LIMIT_S, 60, round time limit in whole seconds. Range 1..63.

Ports:
- pclk  in  1  pixel clock, the only clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a round from IDLE.
- restart  in  1  single-cycle pulse; returns from WON or LOST to IDLE.
- pair_found  in  1  single-cycle pulse; one matched pair.
- game_time  out  13  {seconds[12:7], hundredths[6:0]}; seconds 0..63, hundredths 0..99.
- discovered_pairs_ctr  out  6  pairs found this round.
- game_active  out  1  high in RUNNING.
- endscreen_en  out  1  high in WON or LOST.
- game_over_en  out  1  high in LOST only. Low in WON, so the screen shows the win text.

Behaviour:
- Reset: rst=0 asynchronously forces state IDLE and clears every counter, the prescaler and all outputs to 0.
- All outputs are registered and decoded directly from state and counter registers. They update on the pclk edge after the causing event.
- Prescaler: counts 0..CLK_HZ/100-1, only in RUNNING.
  - tick = prescaler at terminal count.
  - The prescaler is held at 0 in every other state.
- States and transitions:
  - IDLE:
    - start → RUNNING; game_time, discovered_pairs_ctr and prescaler cleared on the same edge.
    - pair_found and restart are ignored.
  - RUNNING:
    - On tick: hundredths+1. At 99 it wraps to 0 and seconds+1.
    - pair_found: discovered_pairs_ctr+1.
    - If the incremented value equals MAX_PAIRS → WON on the same edge.
    - If the next time value equals {TIME_LIMIT_S, 0} → LOST on the same edge, with time frozen at exactly TIME_LIMIT_S.00.
    - start and restart are ignored.
  - WON / LOST:
    - game_time and discovered_pairs_ctr are frozen.
    - restart → IDLE with counters cleared.
    - start and pair_found are ignored.
- Simultaneous events in RUNNING:
  - A completing pair_found on the same cycle as the timeout tick → WON. The tick still applies, so time shows TIME_LIMIT_S.00.
- Saturation: discovered_pairs_ctr never exceeds MAX_PAIRS. Seconds never exceed TIME_LIMIT_S.
- restart and start asserted together in WON/LOST: restart wins, and start is ignored that cycle.
- Reset mid-round: immediate return to IDLE. No endscreen assertion.
- Latency:
  - pair_found → counter visible after 1 cycle.
  - Final pair → endscreen_en high after 1 cycle.

Decomposition:
- Shared package/header (alongside the VGA macros):
  - state encoding localparams: IDLE, RUNNING, WON, LOST.
  - GAME_TIME_W=13, SEC_W=6, HUND_W=7, PAIRS_W=6.
- One natural sub-module: game_timer_bcd_free.
  - Contains the prescaler plus the {seconds, hundredths} counter.
  - Ports: clr, run, tick out, time out, and limit_hit out (asserted when the next value equals the limit).
- The FSM stays in game_flow_ctrl.

Test Plan (CLK_HZ=1000 so tick every 10 cycles, MAX_PAIRS=3, TIME_LIMIT_S=2):
- Reset then idle 50 cycles → all outputs 0; pair_found pulses ignored, ctr stays 0.
- start, wait 1000 cycles → game_time = {1, 0}; game_active=1.
- start, 3 pair_found pulses at cycles 100/200/300 → ctr 1,2,3; endscreen_en=1 and game_over_en=0 one cycle after the 3rd pulse; time frozen at {0,30}.
- start, no pairs → LOST at 2000 cycles; game_time={2,0}, game_over_en=1, endscreen_en=1; time unchanged after 500 more cycles.
- 3rd pair_found on the timeout-tick cycle → WON, game_over_en=0, game_time={2,0}.
- In LOST: restart+start together → IDLE, all 0. Reset asserted mid-RUNNING → IDLE asynchronously; next start begins from {0,0}.
